// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/halt sequencer for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).
// Define PIPELINE_CTRL_PERF_EN to build the saturating stall/flush performance counters.
module pipeline_ctrl #(
  parameter int CNT_WIDTH = 16,
  parameter int DRAIN_MAX = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           rs1_d,
  input  logic [4:0]           rs2_d,
  input  logic                 rs1_used_d,
  input  logic                 rs2_used_d,
  input  logic [4:0]           rd_e,
  input  logic                 mem_read_e,
  input  logic                 branch_taken_e,
  input  logic                 halt_d,
  input  logic                 halt_w,
  input  logic                 mem_busy_m,
  output logic                 pc_wr_en,
  output logic                 if_id_wr_en,
  output logic                 id_ex_wr_en,
  output logic                 ex_mem_wr_en,
  output logic                 mem_wb_wr_en,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 halted,
  output logic                 drain_err,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  localparam int DW = (DRAIN_MAX < 2) ? 1 : $clog2(DRAIN_MAX + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t        state_r;
  logic [DW-1:0] drain_cnt_r;
  logic          halted_r;
  logic          drain_err_r;
  logic          load_use_s;
  logic          stall_s;
  logic          branch_s;
  logic          halt_go_s;

  function automatic logic src_hit(input logic [4:0] rs, input logic used, input logic [4:0] rd);
    return used && (rs == rd);
  endfunction

  // x0 is hardwired zero, so a load targeting it is never a real dependency
  assign load_use_s = mem_read_e && (rd_e != 5'd0) &&
                      (src_hit(rs1_d, rs1_used_d, rd_e) || src_hit(rs2_d, rs2_used_d, rd_e));

  // Enables and flushes decoded from state and the current hazard inputs
  always_comb begin
    pc_wr_en     = 1'b0;
    if_id_wr_en  = 1'b0;
    id_ex_wr_en  = 1'b0;
    ex_mem_wr_en = 1'b0;
    mem_wb_wr_en = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    stall_s      = 1'b0;
    branch_s     = 1'b0;
    halt_go_s    = 1'b0;
    if (rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      case (state_r)
        RUN: begin
          if (mem_busy_m) begin
            pc_wr_en = 1'b0;
          end else if (branch_taken_e) begin
            // halt_d is wrong-path here and gets squashed with the rest of ID
            {pc_wr_en, if_id_wr_en, id_ex_wr_en, ex_mem_wr_en, mem_wb_wr_en} = 5'b11111;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            branch_s    = 1'b1;
          end else if (load_use_s) begin
            {id_ex_wr_en, ex_mem_wr_en, mem_wb_wr_en} = 3'b111;
            id_ex_flush = 1'b1;
            stall_s     = 1'b1;
          end else begin
            {pc_wr_en, if_id_wr_en, id_ex_wr_en, ex_mem_wr_en, mem_wb_wr_en} = 5'b11111;
            halt_go_s = halt_d;
          end
        end
        DRAIN: begin
          if (mem_busy_m) begin
            pc_wr_en = 1'b0;
          end else begin
            {id_ex_wr_en, ex_mem_wr_en, mem_wb_wr_en} = 3'b111;
            if_id_flush = 1'b1;
          end
        end
        HALTED: begin
          pc_wr_en = 1'b0;
        end
        default: begin
          pc_wr_en = 1'b0;
        end
      endcase
    end
  end

  // Run/drain/halt sequencing with drain watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= RUN;
      drain_cnt_r <= '0;
      halted_r    <= 1'b0;
      drain_err_r <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          drain_cnt_r <= '0;
          if (halt_go_s) begin
            state_r <= DRAIN;
          end else begin
            state_r <= RUN;
          end
        end
        DRAIN: begin
          if (halt_w) begin
            state_r  <= HALTED;
            halted_r <= 1'b1;
          end else if (mem_busy_m) begin
            drain_cnt_r <= drain_cnt_r;
          end else if (drain_cnt_r == DW'(DRAIN_MAX - 1)) begin
            state_r     <= HALTED;
            halted_r    <= 1'b1;
            drain_err_r <= 1'b1;
          end else begin
            drain_cnt_r <= drain_cnt_r + DW'(1);
          end
        end
        HALTED: begin
          state_r  <= HALTED;
          halted_r <= 1'b1;
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end
  end

  assign halted    = halted_r && !rst;
  assign drain_err = drain_err_r && !rst;

`ifdef PIPELINE_CTRL_PERF_EN
  logic [CNT_WIDTH-1:0] stall_cnt_r;
  logic [CNT_WIDTH-1:0] flush_cnt_r;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (stall_s && (stall_cnt_r != {CNT_WIDTH{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_WIDTH'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (branch_s && (flush_cnt_r != {CNT_WIDTH{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_WIDTH'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
  logic perf_unused_s;
  assign perf_unused_s = stall_s | branch_s;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
